// File: rtl/cp0_ctrl_if.sv
// CP0 access bus: MTC0/MFC0 port, exception-unit inputs and status outputs to the pipeline.
interface cp0_ctrl_if #(
    parameter int NUM_HW_INT = 6
);
    logic                  cp0we;
    logic [4:0]            cp0wAddr;
    logic [31:0]           cp0wData;
    logic [4:0]            cp0rAddr;
    logic [31:0]           cp0rData;
    logic [NUM_HW_INT-1:0] hw_int;
    logic [31:0]           excptype;
    logic [31:0]           epc_in;
    logic                  in_delay_slot;
    logic [31:0]           bad_addr;
    logic                  int_req;
    logic                  timer_int;
    logic [31:0]           status;
    logic [31:0]           cause;
    logic [31:0]           epc;

    modport master (
        output cp0we, cp0wAddr, cp0wData, cp0rAddr, hw_int,
        output excptype, epc_in, in_delay_slot, bad_addr,
        input  cp0rData, int_req, timer_int, status, cause, epc
    );

    modport slave (
        input  cp0we, cp0wAddr, cp0wData, cp0rAddr, hw_int,
        input  excptype, epc_in, in_delay_slot, bad_addr,
        output cp0rData, int_req, timer_int, status, cause, epc
    );
endinterface

// File: rtl/cp0_ctrl.sv
// MIPS CP0: Count/Compare timer, Status/Cause/EPC/BadVAddr, precise exception entry and ERET.
// Writes land next cycle, reads and int_req are combinational; no backpressure, every input is taken each cycle.
module cp0_ctrl #(
    parameter int          NUM_HW_INT = 6,
    parameter int          TIMER_LINE = 5,
    parameter int          COUNT_DIV  = 1,
    parameter logic [31:0] STATUS_RST = 32'h1000_0000
) (
    input logic       clk,
    input logic       rst,
    cp0_ctrl_if.slave bus
);
    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam logic [1:0] DIV_LAST     = 2'(COUNT_DIV - 1);
    localparam int         EXL          = 1;
    localparam int         IE           = 0;

    logic [31:0]           count_q;
    logic [31:0]           compare_q;
    logic [31:0]           status_q;
    logic [31:0]           epc_q;
    logic [31:0]           badvaddr_q;
    logic [1:0]            div_q;
    logic                  timer_q;
    logic [NUM_HW_INT-1:0] hw_ip_q;
    logic                  cause_bd_q;
    logic                  cause_iv_q;
    logic                  cause_wp_q;
    logic [1:0]            cause_sw_q;
    logic [4:0]            cause_exc_q;

    logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;
    logic        tick, timer_hit;
    logic [31:0] count_inc;
    logic        exc_take, exc_addr, eret;
    logic [4:0]  exc_code;
    logic [31:0] status_d, epc_d;
    logic        bd_d;
    logic [5:0]  ip_hw;
    logic [31:0] cause_w;
    logic [31:0] rd_dat;

    assign wr_count   = bus.cp0we && (bus.cp0wAddr == REG_COUNT);
    assign wr_compare = bus.cp0we && (bus.cp0wAddr == REG_COMPARE);
    assign wr_status  = bus.cp0we && (bus.cp0wAddr == REG_STATUS);
    assign wr_cause   = bus.cp0we && (bus.cp0wAddr == REG_CAUSE);
    assign wr_epc     = bus.cp0we && (bus.cp0wAddr == REG_EPC);

    assign tick      = (div_q == DIV_LAST);
    assign count_inc = count_q + 32'd1;
    // A Count write suppresses the increment, so it can never produce a match that cycle.
    assign timer_hit = tick && !wr_count && (count_inc == compare_q) && (compare_q != 32'd0);

    always_comb begin
        exc_take = 1'b0;
        exc_addr = 1'b0;
        exc_code = 5'd0;
        eret     = 1'b0;
        case (bus.excptype)
            32'h01: exc_take = 1'b1;
            32'h04, 32'h05: begin
                exc_take = 1'b1;
                exc_addr = 1'b1;
                exc_code = bus.excptype[4:0];
            end
            32'h08, 32'h0a, 32'h0c, 32'h0d: begin
                exc_take = 1'b1;
                exc_code = bus.excptype[4:0];
            end
            32'h0e:  eret = 1'b1;
            default: ;
        endcase
    end

    // MTC0 lands first; exception/ERET then overrides only the fields it owns.
    always_comb begin
        status_d = wr_status ? bus.cp0wData : status_q;
        if (exc_take) begin
            status_d[EXL] = 1'b1;
        end else if (eret) begin
            status_d[EXL] = 1'b0;
        end
        epc_d = wr_epc ? bus.cp0wData : epc_q;
        bd_d  = cause_bd_q;
        if (exc_take && !status_q[EXL]) begin
            epc_d = bus.in_delay_slot ? (bus.epc_in - 32'd4) : bus.epc_in;
            bd_d  = bus.in_delay_slot;
        end
    end

    always_comb begin
        ip_hw = '0;
        for (int i = 0; i < NUM_HW_INT; i++) begin
            ip_hw[i] = hw_ip_q[i];
        end
        ip_hw[TIMER_LINE] = ip_hw[TIMER_LINE] | timer_q;
    end

    assign cause_w = {cause_bd_q, timer_q, 6'b0, cause_iv_q, cause_wp_q, 6'b0,
                      ip_hw, cause_sw_q, 1'b0, cause_exc_q, 2'b0};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q     <= '0;
            compare_q   <= '0;
            status_q    <= STATUS_RST;
            epc_q       <= '0;
            badvaddr_q  <= '0;
            div_q       <= '0;
            timer_q     <= 1'b0;
            hw_ip_q     <= '0;
            cause_bd_q  <= 1'b0;
            cause_iv_q  <= 1'b0;
            cause_wp_q  <= 1'b0;
            cause_sw_q  <= '0;
            cause_exc_q <= '0;
        end else begin
            if (wr_count) begin
                count_q <= bus.cp0wData;
                div_q   <= '0;
            end else if (tick) begin
                count_q <= count_inc;
                div_q   <= '0;
            end else begin
                div_q <= div_q + 2'd1;
            end
            if (wr_compare) begin
                compare_q <= bus.cp0wData;
            end
            if (wr_compare) begin
                timer_q <= 1'b0;
            end else if (timer_hit) begin
                timer_q <= 1'b1;
            end
            hw_ip_q    <= bus.hw_int;
            status_q   <= status_d;
            epc_q      <= epc_d;
            cause_bd_q <= bd_d;
            if (exc_take) begin
                cause_exc_q <= exc_code;
            end
            if (exc_take && exc_addr) begin
                badvaddr_q <= bus.bad_addr;
            end
            if (wr_cause) begin
                cause_sw_q <= bus.cp0wData[9:8];
                cause_iv_q <= bus.cp0wData[23];
                cause_wp_q <= bus.cp0wData[22];
            end
        end
    end

    // Read port is forced to zero while reset is held.
    always_comb begin
        rd_dat = '0;
        if (rst) begin
            case (bus.cp0rAddr)
                REG_BADVADDR: rd_dat = badvaddr_q;
                REG_COUNT:    rd_dat = count_q;
                REG_COMPARE:  rd_dat = compare_q;
                REG_STATUS:   rd_dat = status_q;
                REG_CAUSE:    rd_dat = cause_w;
                REG_EPC:      rd_dat = epc_q;
                default:      rd_dat = '0;
            endcase
        end
    end

    assign bus.cp0rData  = rd_dat;
    assign bus.status    = status_q;
    assign bus.cause     = cause_w;
    assign bus.epc       = epc_q;
    assign bus.timer_int = timer_q;
    assign bus.int_req   = status_q[IE] & ~status_q[EXL] & (|(cause_w[15:8] & status_q[15:8]));
endmodule

// File: tb/tb_cp0_ctrl.sv
// Randomised bench for cp0_ctrl: two configurations checked against a field-level model of CP0.
module tb_cp0_ctrl;
    localparam logic [31:0] RST0 = 32'h1000_0000;
    localparam logic [31:0] RST1 = 32'h0040_0000;

    typedef struct packed {
        logic [31:0] count;
        logic [31:0] compare;
        logic [31:0] status;
        logic [31:0] epc;
        logic [31:0] badv;
        logic        timer;
        logic [2:0]  phase;
        logic [5:0]  hw;
        logic        bd;
        logic [4:0]  code;
        logic [1:0]  sw;
        logic        iv;
        logic        wp;
    } model_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cp0_ctrl_if #(.NUM_HW_INT(6)) bus0 ();
    cp0_ctrl_if #(.NUM_HW_INT(4)) bus1 ();

    cp0_ctrl #(.NUM_HW_INT(6), .TIMER_LINE(5), .COUNT_DIV(1), .STATUS_RST(RST0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    cp0_ctrl #(.NUM_HW_INT(4), .TIMER_LINE(2), .COUNT_DIV(2), .STATUS_RST(RST1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic        t_we;
    logic [4:0]  t_waddr, t_raddr;
    logic [31:0] t_wdata, t_exc, t_epc, t_bad;
    logic [5:0]  t_hw;
    logic        t_ds;
    model_t      m0, m1;

    function automatic int cfg_div(int k);   return (k == 0) ? 1 : 2; endfunction
    function automatic int cfg_nhw(int k);   return (k == 0) ? 6 : 4; endfunction
    function automatic int cfg_tline(int k); return (k == 0) ? 5 : 2; endfunction

    function automatic model_t model_reset(int k);
        model_t m;
        m = '0;
        m.status = (k == 0) ? RST0 : RST1;
        return m;
    endfunction

    function automatic model_t step(model_t m, int k);
        model_t n;
        logic   hit;
        n   = m;
        hit = 1'b0;
        if (t_we && t_waddr == 5'd9) begin
            n.count = t_wdata;
            n.phase = 3'd0;
        end else if (int'(m.phase) == cfg_div(k) - 1) begin
            n.phase = 3'd0;
            n.count = m.count + 32'd1;
            hit     = (n.count == m.compare) && (m.compare != 32'd0);
        end else begin
            n.phase = m.phase + 3'd1;
        end
        if (t_we && t_waddr == 5'd11) begin
            n.compare = t_wdata;
            n.timer   = 1'b0;
        end else if (hit) begin
            n.timer = 1'b1;
        end
        n.hw = 6'(32'(t_hw) & ((32'd1 << cfg_nhw(k)) - 32'd1));
        if (t_we) begin
            case (t_waddr)
                5'd12: n.status = t_wdata;
                5'd14: n.epc    = t_wdata;
                5'd13: begin
                    n.sw = t_wdata[9:8];
                    n.iv = t_wdata[23];
                    n.wp = t_wdata[22];
                end
                default: ;
            endcase
        end
        if (t_exc inside {32'h1, 32'h4, 32'h5, 32'h8, 32'ha, 32'hc, 32'hd}) begin
            n.status[1] = 1'b1;
            n.code      = (t_exc == 32'h1) ? 5'd0 : t_exc[4:0];
            if (!m.status[1]) begin
                n.epc = t_ds ? t_epc - 32'd4 : t_epc;
                n.bd  = t_ds;
            end
            if (t_exc == 32'h4 || t_exc == 32'h5) n.badv = t_bad;
        end else if (t_exc == 32'he) begin
            n.status[1] = 1'b0;
        end
        return n;
    endfunction

    function automatic logic [31:0] exp_cause(model_t m, int k);
        logic [31:0] ip;
        ip = 32'(m.hw);
        if (m.timer) ip = ip | (32'd1 << cfg_tline(k));
        return (32'(m.bd) << 31) | (32'(m.timer) << 30) | (32'(m.iv) << 23) | (32'(m.wp) << 22)
             | (ip << 10) | (32'(m.sw) << 8) | (32'(m.code) << 2);
    endfunction

    function automatic logic [31:0] exp_rd(model_t m, int k, logic [4:0] a);
        case (a)
            5'd8:    return m.badv;
            5'd9:    return m.count;
            5'd11:   return m.compare;
            5'd12:   return m.status;
            5'd13:   return exp_cause(m, k);
            5'd14:   return m.epc;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic exp_int(model_t m, int k);
        return m.status[0] && !m.status[1]
            && (((exp_cause(m, k) >> 8) & (m.status >> 8) & 32'hFF) != 32'd0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra, input logic [5:0] hw, input logic [31:0] exc,
                         input logic [31:0] epcin, input logic ds, input logic [31:0] bad);
        t_we = we; t_waddr = wa; t_wdata = wd; t_raddr = ra; t_hw = hw;
        t_exc = exc; t_epc = epcin; t_ds = ds; t_bad = bad;
        bus0.cp0we = we; bus0.cp0wAddr = wa; bus0.cp0wData = wd; bus0.cp0rAddr = ra;
        bus0.hw_int = hw; bus0.excptype = exc; bus0.epc_in = epcin;
        bus0.in_delay_slot = ds; bus0.bad_addr = bad;
        bus1.cp0we = we; bus1.cp0wAddr = wa; bus1.cp0wData = wd; bus1.cp0rAddr = ra;
        bus1.hw_int = hw[3:0]; bus1.excptype = exc; bus1.epc_in = epcin;
        bus1.in_delay_slot = ds; bus1.bad_addr = bad;
    endtask

    task automatic idle(input logic [4:0] ra);
        drive(1'b0, 5'd0, 32'd0, ra, 6'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic check_all();
        chk("d0.status", bus0.status, m0.status);
        chk("d0.cause", bus0.cause, exp_cause(m0, 0));
        chk("d0.epc", bus0.epc, m0.epc);
        chk("d0.timer_int", 32'(bus0.timer_int), 32'(m0.timer));
        chk("d0.int_req", 32'(bus0.int_req), 32'(exp_int(m0, 0)));
        chk("d0.rdata", bus0.cp0rData, exp_rd(m0, 0, t_raddr));
        chk("d1.status", bus1.status, m1.status);
        chk("d1.cause", bus1.cause, exp_cause(m1, 1));
        chk("d1.epc", bus1.epc, m1.epc);
        chk("d1.timer_int", 32'(bus1.timer_int), 32'(m1.timer));
        chk("d1.int_req", 32'(bus1.int_req), 32'(exp_int(m1, 1)));
        chk("d1.rdata", bus1.cp0rData, exp_rd(m1, 1, t_raddr));
    endtask

    task automatic cycle();
        @(posedge clk);
        m0 = step(m0, 0);
        m1 = step(m1, 1);
        @(negedge clk);
        check_all();
    endtask

    task automatic rand_drive();
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd, exc;
        we = ($urandom_range(0, 2) == 0);
        case ($urandom_range(0, 7))
            0:       wa = 5'd8;
            1:       wa = 5'd9;
            2:       wa = 5'd11;
            3, 4:    wa = 5'd12;
            5:       wa = 5'd13;
            6:       wa = 5'd14;
            default: wa = 5'($urandom_range(0, 31));
        endcase
        wd = $urandom;
        if (wa == 5'd9)  wd = $urandom_range(0, 20);
        if (wa == 5'd11) wd = $urandom_range(0, 24);
        if (wa == 5'd12) wd = $urandom & 32'h0000_FF03;
        exc = 32'd0;
        if ($urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 9))
                0:       exc = 32'h01;
                1:       exc = 32'h04;
                2:       exc = 32'h05;
                3:       exc = 32'h08;
                4:       exc = 32'h0a;
                5:       exc = 32'h0c;
                6:       exc = 32'h0d;
                7, 8:    exc = 32'h0e;
                default: exc = $urandom_range(15, 40);
            endcase
        end
        drive(we, wa, wd, 5'($urandom_range(0, 15)), 6'($urandom), exc,
              $urandom & ~32'h3, 1'($urandom), $urandom);
    endtask

    initial begin
        idle(5'd12);
        repeat (2) @(negedge clk);
        chk("rst.d0.status", bus0.status, RST0);
        chk("rst.d1.status", bus1.status, RST1);
        chk("rst.d0.rdata", bus0.cp0rData, 32'd0);
        rst = 1'b1;
        m0 = model_reset(0);
        m1 = model_reset(1);
        #1 check_all();

        // Timer: Compare=5, Count=0, fires on the fifth increment.
        drive(1'b1, 5'd11, 32'd5, 5'd9, 6'd0, 32'd0, 32'd0, 1'b0, 32'd0); cycle();
        drive(1'b1, 5'd9, 32'd0, 5'd9, 6'd0, 32'd0, 32'd0, 1'b0, 32'd0);  cycle();
        for (int i = 1; i <= 5; i++) begin
            idle(5'd9); cycle();
            chk("timer.rise", 32'(bus0.timer_int), (i == 5) ? 32'd1 : 32'd0);
        end
        idle(5'd13); cycle();
        chk("timer.sticky", 32'(bus0.timer_int), 32'd1);
        chk("timer.cause15", 32'(bus0.cause[15]), 32'd1);
        chk("timer.ti", 32'(bus0.cause[30]), 32'd1);
        drive(1'b1, 5'd11, 32'h20, 5'd11, 6'd0, 32'd0, 32'd0, 1'b0, 32'd0); cycle();
        chk("timer.clear", 32'(bus0.timer_int), 32'd0);

        // Interrupt masking.
        drive(1'b1, 5'd12, 32'h401, 5'd13, 6'd1, 32'd0, 32'd0, 1'b0, 32'd0); cycle();
        chk("mask.ip2", 32'(bus0.cause[10]), 32'd1);
        chk("mask.req", 32'(bus0.int_req), 32'd1);
        drive(1'b1, 5'd12, 32'h403, 5'd13, 6'd1, 32'd0, 32'd0, 1'b0, 32'd0); cycle();
        chk("mask.exl", 32'(bus0.int_req), 32'd0);

        // Delay-slot syscall, then a nested exception.
        drive(1'b1, 5'd12, 32'h0, 5'd12, 6'd0, 32'd0, 32'd0, 1'b0, 32'd0); cycle();
        drive(1'b0, 5'd0, 32'd0, 5'd14, 6'd0, 32'h08, 32'hBFC0_0100, 1'b1, 32'd0); cycle();
        chk("sys.epc", bus0.epc, 32'hBFC0_00FC);
        chk("sys.bd", 32'(bus0.cause[31]), 32'd1);
        chk("sys.code", 32'(bus0.cause[6:2]), 32'd8);
        chk("sys.exl", 32'(bus0.status[1]), 32'd1);
        drive(1'b0, 5'd0, 32'd0, 5'd14, 6'd0, 32'h0c, 32'h0000_1234, 1'b0, 32'd0); cycle();
        chk("nest.epc", bus0.epc, 32'hBFC0_00FC);
        chk("nest.code", 32'(bus0.cause[6:2]), 32'd12);
        idle(5'd12); t_exc = 32'h0e; bus0.excptype = 32'h0e; bus1.excptype = 32'h0e; cycle();

        // AdEL racing an MTC0 Status=0.
        drive(1'b1, 5'd12, 32'h0, 5'd8, 6'd0, 32'h04, 32'h8000_0040, 1'b0, 32'h8000_0003); cycle();
        chk("adel.badv", bus0.cp0rData, 32'h8000_0003);
        chk("adel.code", 32'(bus0.cause[6:2]), 32'd4);
        chk("adel.status", bus0.status, 32'h0000_0002);

        // Count wrap with the divide-by-two instance, then ERET.
        drive(1'b1, 5'd9, 32'hFFFF_FFFF, 5'd9, 6'd0, 32'd0, 32'd0, 1'b0, 32'd0); cycle();
        idle(5'd9); cycle();
        chk("wrap.hold", bus1.cp0rData, 32'hFFFF_FFFF);
        idle(5'd9); cycle();
        chk("wrap.zero", bus1.cp0rData, 32'd0);
        drive(1'b0, 5'd0, 32'd0, 5'd14, 6'd0, 32'h0e, 32'd0, 1'b0, 32'd0); cycle();
        chk("eret.exl", 32'(bus0.status[1]), 32'd0);
        chk("eret.epc", bus0.epc, 32'h8000_0040);

        for (int i = 0; i < 600; i++) begin
            rand_drive(); cycle();
        end

        // Asynchronous reset mid-cycle.
        drive(1'b1, 5'd9, 32'h1234, 5'd12, 6'd0, 32'd0, 32'd0, 1'b0, 32'd0); cycle();
        idle(5'd12);
        #2 rst = 1'b0;
        #1;
        chk("arst.status", bus0.status, RST0);
        chk("arst.cause", bus0.cause, 32'd0);
        chk("arst.epc", bus0.epc, 32'd0);
        chk("arst.timer", 32'(bus0.timer_int), 32'd0);
        chk("arst.rdata", bus0.cp0rData, 32'd0);
        chk("arst.d1.status", bus1.status, RST1);
        @(negedge clk);
        rst = 1'b1;
        m0 = model_reset(0);
        m1 = model_reset(1);
        idle(5'd9); cycle();
        chk("arst.count", bus0.cp0rData, 32'd1);
        for (int i = 0; i < 60; i++) begin
            rand_drive(); cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
